// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: forwarding, load-use, branch flush, multi-cycle and memory stalls
module hazard_ctrl #(
   parameter int AW      = 5,
   parameter int MC_LAT  = 4,
   parameter int CNT_W   = 16,
   parameter int ZERO_HW = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    rs1_d,
   input  logic [AW-1:0]    rs2_d,
   input  logic             uses_rs1_d,
   input  logic             uses_rs2_d,
   input  logic [AW-1:0]    rs1_e,
   input  logic [AW-1:0]    rs2_e,
   input  logic [AW-1:0]    rd_e,
   input  logic             resultsrc_e0,
   input  logic [AW-1:0]    rd_m,
   input  logic [AW-1:0]    rd_w,
   input  logic             regwrite_m,
   input  logic             regwrite_w,
   input  logic             pcsrc_e,
   input  logic             mc_start_e,
   input  logic             dmem_ready_m,
   input  logic             stat_clr,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_m,
   output logic             flush_w,
   output logic [1:0]       forward_ae,
   output logic [1:0]       forward_be,
   output logic             mc_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] MC_INIT = 8'(MC_LAT - 2);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       mc_stall;
   logic       freeze;
   logic       lw;

   // Register 0 never matches when it is hardwired.
   function automatic logic reg_match(input logic [AW-1:0] src, input logic [AW-1:0] dst);
      return (src == dst) && !((ZERO_HW != 0) && (dst == '0));
   endfunction

   always_comb begin
      forward_ae = 2'b00;
      if (regwrite_m && reg_match(rs1_e, rd_m))
         forward_ae = 2'b10;
      else if (regwrite_w && reg_match(rs1_e, rd_w))
         forward_ae = 2'b01;
   end

   always_comb begin
      forward_be = 2'b00;
      if (regwrite_m && reg_match(rs2_e, rd_m))
         forward_be = 2'b10;
      else if (regwrite_w && reg_match(rs2_e, rd_w))
         forward_be = 2'b01;
   end

   assign lw = resultsrc_e0 &&
               ((uses_rs1_d && reg_match(rs1_d, rd_e)) ||
                (uses_rs2_d && reg_match(rs2_d, rd_e)));

   assign freeze  = !dmem_ready_m;
   assign mc_busy = (state == BUSY);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      mc_stall = 1'b0;
      case (state)
         IDLE: begin
            if (mc_start_e) begin
               mc_stall = 1'b1;
               if (!freeze) begin
                  state_nx = BUSY;
                  cnt_nx   = MC_INIT;
               end
            end
         end
         BUSY: begin
            // Final busy cycle releases the pipeline and ignores a new start.
            if (cnt != 8'd0) begin
               mc_stall = 1'b1;
               if (!freeze)
                  cnt_nx = cnt - 8'd1;
            end else if (!freeze) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      flush_w = 1'b0;
      if (rst_n) begin
         if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
         end else if (mc_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
         end else if (pcsrc_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (lw) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (stat_clr)
         stall_cnt <= '0;
      else if (stall_f && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

   localparam int AW      = 5;
   localparam int MC_LAT  = 4;
   localparam int CNT_W   = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk, rst_n;
   logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic uses_rs1_d, uses_rs2_d, resultsrc_e0, regwrite_m, regwrite_w;
   logic pcsrc_e, mc_start_e, dmem_ready_m, stat_clr;
   logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
   logic [1:0] forward_ae, forward_be;
   logic mc_busy;
   logic [CNT_W-1:0] stall_cnt;

   hazard_ctrl #(.AW(AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W), .ZERO_HW(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .resultsrc_e0(resultsrc_e0),
      .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
      .pcsrc_e(pcsrc_e), .mc_start_e(mc_start_e), .dmem_ready_m(dmem_ready_m), .stat_clr(stat_clr),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
      .forward_ae(forward_ae), .forward_be(forward_be), .mc_busy(mc_busy), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int m_rem  = 0;   // cycles the multi-cycle op still holds Execute, 0 = none
   int m_cnt  = 0;
   int cnt0;
   int exp_sf31[4]  = '{1, 1, 1, 0};
   int exp_bz31[4]  = '{0, 1, 1, 1};
   int dm32[6]      = '{1, 0, 0, 1, 1, 1};
   int exp_sf32[6]  = '{1, 1, 1, 1, 1, 0};
   int exp_fw32[6]  = '{0, 1, 1, 0, 0, 0};
   int exp_bz32[7]  = '{0, 1, 1, 1, 1, 1, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}
   function automatic logic [7:0] ref_ctl();
      logic mcs, ld;
      if (!rst_n) return 8'h00;
      mcs = (m_rem == 0) ? mc_start_e : (m_rem > 1);
      ld  = resultsrc_e0 && (rd_e != 0) &&
            ((uses_rs1_d && rs1_d == rd_e) || (uses_rs2_d && rs2_d == rd_e));
      if (!dmem_ready_m) return 8'b1111_0001;
      if (mcs)           return 8'b1110_0010;
      if (pcsrc_e)       return 8'b0000_1100;
      if (ld)            return 8'b1100_0100;
      return 8'h00;
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [AW-1:0] src);
      if (src == 0) return 2'b00;
      if (regwrite_m && src == rd_m) return 2'b10;
      if (regwrite_w && src == rd_w) return 2'b01;
      return 2'b00;
   endfunction

   task automatic idle_inputs();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      uses_rs1_d = 0; uses_rs2_d = 0; resultsrc_e0 = 0; regwrite_m = 0; regwrite_w = 0;
      pcsrc_e = 0; mc_start_e = 0; dmem_ready_m = 1; stat_clr = 0;
   endtask

   // Entered just after a falling edge with inputs driven; returns at the next falling edge.
   task automatic cycle();
      logic [7:0] ctl;
      if (!rst_n) begin
         m_rem = 0;
         m_cnt = 0;
      end
      #1;
      ctl = ref_ctl();
      chk("ctl", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}, ctl);
      chk("fwd_a", forward_ae, ref_fwd(rs1_e));
      chk("fwd_b", forward_be, ref_fwd(rs2_e));
      chk("mc_busy", mc_busy, (m_rem > 0));
      chk("stall_cnt", stall_cnt, m_cnt);
      @(posedge clk);
      if (rst_n) begin
         if (stat_clr) m_cnt = 0;
         else if (ctl[7] && m_cnt < CNT_MAX) m_cnt++;
         if (dmem_ready_m) begin
            if (m_rem == 0 && mc_start_e) m_rem = MC_LAT - 1;
            else if (m_rem > 0) m_rem--;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);

      // Reset: controls forced low, forwarding still live
      mc_start_e = 1; pcsrc_e = 1; dmem_ready_m = 0;
      rs1_e = 3; rd_m = 3; regwrite_m = 1;
      #1 chk("rst_fwd", forward_ae, 2'b10);
      cycle();
      idle_inputs();
      rst_n = 1'b1;
      cycle();

      // Forwarding priority and register 0
      rd_m = 3; rd_w = 3; rs1_e = 3; regwrite_m = 1; regwrite_w = 1;
      #1 chk("fwd_mem", forward_ae, 2'b10);
      cycle();
      regwrite_m = 0;
      #1 chk("fwd_wb", forward_ae, 2'b01);
      cycle();
      regwrite_m = 1; rs1_e = 0; rd_m = 0; rd_w = 0;
      #1 chk("fwd_zero", forward_ae, 2'b00);
      cycle();

      // Load-use
      idle_inputs();
      resultsrc_e0 = 1; rd_e = 7; rs2_d = 7; uses_rs2_d = 1;
      #1 chk("lw_stall", {stall_f, stall_d, flush_e}, 3'b111);
      cycle();
      uses_rs2_d = 0;
      #1 chk("lw_unused", {stall_f, stall_d, flush_e}, 3'b000);
      cycle();

      // Multi-cycle op, start held four cycles
      idle_inputs();
      cnt0 = m_cnt;
      for (int i = 0; i < 4; i++) begin
         mc_start_e = 1;
         #1 chk("mc_stall_f", stall_f, exp_sf31[i]);
         chk("mc_busy_seq", mc_busy, exp_bz31[i]);
         cycle();
      end
      mc_start_e = 0;
      chk("mc_cnt_plus3", stall_cnt, cnt0 + 3);
      cycle();

      // Memory freeze during a multi-cycle op
      for (int i = 0; i < 7; i++) begin
         mc_start_e   = (i == 0);
         dmem_ready_m = (i < 6) ? dm32[i] : 1'b1;
         #1 chk("frz_busy", mc_busy, exp_bz32[i]);
         if (i < 6) begin
            chk("frz_stall_f", stall_f, exp_sf32[i]);
            chk("frz_flush_w", flush_w, exp_fw32[i]);
         end
         cycle();
      end

      // Branch beats load-use
      idle_inputs();
      resultsrc_e0 = 1; rd_e = 5; rs1_d = 5; uses_rs1_d = 1; pcsrc_e = 1;
      #1 chk("br_over_lw", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w},
             8'b0000_1100);
      cycle();

      // Saturation and clear
      pcsrc_e = 0;
      for (int i = 0; i < CNT_MAX + 4; i++) cycle();
      chk("cnt_sat", stall_cnt, CNT_MAX);
      cycle();
      chk("cnt_hold", stall_cnt, CNT_MAX);
      stat_clr = 1;
      cycle();
      chk("cnt_clr", stall_cnt, 0);
      idle_inputs();

      // Reset mid-busy takes effect without a clock
      mc_start_e = 1;
      cycle();
      mc_start_e = 0;
      #1 chk("pre_rst_busy", mc_busy, 1'b1);
      rst_n = 1'b0;
      #1 chk("rst_busy_now", mc_busy, 1'b0);
      chk("rst_cnt_now", stall_cnt, 0);
      @(negedge clk);
      cycle();
      rst_n = 1'b1;
      mc_start_e = 1;
      cycle();
      mc_start_e = 0;

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rs1_d = AW'($urandom_range(0, 3)); rs2_d = AW'($urandom_range(0, 3));
         rs1_e = AW'($urandom_range(0, 3)); rs2_e = AW'($urandom_range(0, 3));
         rd_e  = AW'($urandom_range(0, 3)); rd_m  = AW'($urandom_range(0, 3));
         rd_w  = AW'($urandom_range(0, 3));
         uses_rs1_d   = 1'($urandom_range(0, 1));
         uses_rs2_d   = 1'($urandom_range(0, 1));
         resultsrc_e0 = 1'($urandom_range(0, 1));
         regwrite_m   = 1'($urandom_range(0, 1));
         regwrite_w   = 1'($urandom_range(0, 1));
         pcsrc_e      = ($urandom_range(0, 99) < 15);
         mc_start_e   = ($urandom_range(0, 99) < 12);
         dmem_ready_m = ($urandom_range(0, 99) < 85);
         stat_clr     = ($urandom_range(0, 99) < 3);
         rst_n        = ($urandom_range(0, 99) >= 2);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
Parameters:
REQ-001 SHALL: AW, 5, register-address width.
REQ-002 SHALL: MC_LAT, 4, total cycles a multi-cycle (mul/div) op occupies Execute; legal range 2..255.
REQ-003 SHALL: CNT_W, 16, stall-counter width.
REQ-004 SHALL: ZERO_HW, 1, when 1 register 0 is hardwired and never forwarded or stalled on; when 0 register 0 is treated as ordinary.

Ports:
REQ-005 SHALL: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL: rs1_d, rs2_d  in  AW  Decode sources; uses_rs1_d, uses_rs2_d  in  1  source actually read.
REQ-007 SHALL: rs1_e, rs2_e, rd_e  in  AW  Execute sources/destination; resultsrc_e0  in  1  load in Execute.
REQ-008 SHALL: rd_m, rd_w  in  AW; regwrite_m, regwrite_w  in  1  Memory/Writeback destination and write enable.
REQ-009 SHALL: pcsrc_e  in  1  branch/jump taken; mc_start_e  in  1  multi-cycle op in Execute; dmem_ready_m  in  1  data memory done; stat_clr  in  1  clear stall counter.
REQ-010 SHALL: stall_f, stall_d, stall_e, stall_m  out  1  stage hold enables.
REQ-011 SHALL: flush_d, flush_e, flush_m, flush_w  out  1  bubble insertion into the named stage register.
REQ-012 SHALL: forward_ae, forward_be  out  2  00 regfile, 01 Writeback, 10 Memory; mc_busy  out  1; stall_cnt  out  CNT_W.

Function
REQ-013 SHALL: forward_ae = 10 if rs1_e==rd_m && regwrite_m, else 01 if rs1_e==rd_w && regwrite_w, else 00; zero-register match excluded when ZERO_HW=1; forward_be identical on rs2_e; purely combinational, valid during stalls.
REQ-014 SHALL: lw = resultsrc_e0 && ((uses_rs1_d && rs1_d==rd_e) || (uses_rs2_d && rs2_d==rd_e)), with rd_e==0 excluded when ZERO_HW=1.
REQ-015 SHALL: MC FSM states IDLE and BUSY with an 8-bit down-counter cnt.
REQ-016 SHALL: IDLE && mc_start_e && !freeze -> mc_stall=1 this cycle, cnt<=MC_LAT-2, next BUSY.
REQ-017 SHALL: BUSY && cnt!=0 -> mc_stall=1, cnt<=cnt-1; BUSY && cnt==0 -> mc_stall=0, next IDLE, mc_start_e ignored this cycle; total stall = MC_LAT-1 cycles per op.
REQ-018 SHALL: mc_busy = (state==BUSY).
REQ-019 SHALL: freeze = !dmem_ready_m; while freeze: stall_f=stall_d=stall_e=stall_m=1, flush_w=1, all other flushes 0, FSM state and cnt held.
REQ-020 SHALL: else if mc_stall: stall_f=stall_d=stall_e=1, flush_m=1, others 0; pcsrc_e and lw ignored.
REQ-021 SHALL: else if pcsrc_e: flush_d=flush_e=1, no stalls; a concurrent lw is suppressed.
REQ-022 SHALL: else if lw: stall_f=stall_d=1, flush_e=1.
REQ-023 SHALL: else all stall/flush outputs 0.
REQ-024 SHALL: stall_cnt increments by 1 on each edge where stall_f==1, saturating at all-ones, with stat_clr (synchronous) taking priority over increment.
REQ-025 SHALL: mc_start_e and pcsrc_e are mutually exclusive by decode; only REQ-020 defines behaviour when both are high.

Reset
REQ-026 SHALL: rst_n low -> state IDLE, cnt 0, stall_cnt 0, mc_busy 0 immediately, without waiting for a clock edge.
REQ-027 SHALL: while rst_n low all stall_*/flush_* outputs are 0 regardless of inputs; forwarding stays combinational.
REQ-028 SHALL: reset asserted mid-BUSY abandons the op, and the first edge after release evaluates from IDLE.

Verification
REQ-029 SHALL: rd_m=rd_w=rs1_e=3, regwrite_m=regwrite_w=1 -> forward_ae=10; regwrite_m=0 -> 01; rs1_e=rd_m=0 with ZERO_HW=1 -> 00.
REQ-030 SHALL: resultsrc_e0=1, rd_e=7, rs2_d=7, uses_rs2_d=1 -> stall_f=stall_d=flush_e=1 for one cycle; same stimulus with uses_rs2_d=0 -> no stall.
REQ-031 SHALL: MC_LAT=4, mc_start_e held high 4 cycles -> stall_f/d/e and flush_m high for exactly cycles 1-3, low in cycle 4, mc_busy high cycles 2-4, stall_cnt +3.
REQ-032 SHALL: dmem_ready_m=0 for 2 cycles during cycle 2 of an MC op -> all four stalls plus flush_w high, cnt frozen, MC release delayed exactly 2 cycles.
REQ-033 SHALL: pcsrc_e=1 with lw condition true -> flush_d=flush_e=1, stall_f=stall_d=0.
REQ-034 SHALL: stall_cnt preset near all-ones via sustained stalls saturates and holds; stat_clr=1 -> 0 next edge; rst_n pulsed mid-BUSY -> mc_busy=0 immediately.
